keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Active scanner for the 4x3 telephone keypad matrix that sets stopwatch digits. It drives the column lines one-hot in rotation, synchronizes and samples the row returns, debounces a single pressed key and locks onto it until release. It reports each accepted press as a 4-bit key code on `Num` with a one-cycle `Enable` strobe, for the stopwatch digit-entry logic.

## Interface
- `SCAN_DIV`, default 16: clock cycles each column is driven; minimum 4.
- `DEBOUNCE`, default 1024: consecutive stable cycles required to accept a press or a release; minimum 2.
- `clk` input 1: single clock; all logic rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `R1`..`R4` input 1 each: row returns, active-high, asynchronous to `clk`.
- `C1`..`C3` output 1 each: column drives, active-high, exactly one high at all times.
- `Num` output 4: code of last accepted key.
- `Enable` output 1: one-cycle strobe marking a newly accepted key.

## Operation
- Key codes: R1 gives 1,2,3 on C1,C2,C3. R2 gives 4,5,6. R3 gives 7,8,9. R4 gives `*`=4'hA on C1, 0 on C2, `#`=4'hB on C3.
- Rows pass through a 2-flop synchronizer before any use. `rowv` is the synchronized 4-bit vector.
- A row pattern is valid when exactly one bit of `rowv` is set. Zero bits or two or more bits mean no key.
- SCAN state:
  - The column index steps C1 to C2 to C3 to C1. Each step occurs after `SCAN_DIV` cycles.
  - `rowv` is sampled only in the last cycle of each column slot.
  - A valid sample latches the column and row, clears the debounce counter and moves to PRESS_DB. The column drive freezes.
- PRESS_DB state:
  - Each cycle `rowv` equals the latched row, the counter increments.
  - Any other value returns the block to SCAN. Scanning resumes at the next column.
  - When the counter reaches `DEBOUNCE`-1, the block moves to HELD. `Num` takes the code and `Enable` pulses for 1 cycle.
- HELD state: the column stays frozen. When `rowv` is all zero, the counter clears and the block moves to REL_DB.
- REL_DB state:
  - Any nonzero `rowv` returns the block to HELD. There is no new `Enable`.
  - `DEBOUNCE` consecutive zero cycles return the block to SCAN at the next column.
- A second key pressed while HELD is ignored. Only full release re-arms detection.
- `Num` holds its value until the next accepted press.

## Timing
- Reset values: C1=1, C2=0, C3=0, `Num`=4'h0, `Enable`=0, state SCAN, column counter 0, debounce counter 0, synchronizer flops 0.
- `rst` mid-operation overrides every state within one cycle. Any pending press is discarded.
- Pin to `rowv` latency is 2 cycles. Because `SCAN_DIV` is at least 4, the sampled value always reflects the current column.
- Press latency is the slot-end sample plus `DEBOUNCE` cycles. `Enable` is asserted in the cycle after the counter hits `DEBOUNCE`-1.
- `Enable` is registered, high for exactly 1 cycle per press and never high in two consecutive cycles. `Num` is valid in the same cycle as `Enable`.
- Counter widths: `$clog2(SCAN_DIV)` and `$clog2(DEBOUNCE+1)`. Neither counter wraps within a state, and each is cleared on every state entry.
- On column wrap, C3 steps to C1 with no idle cycle.

## Structure
- The package `keypad_pkg` holds:
  - the state enum `kp_state_t` with values SCAN, PRESS_DB, HELD, REL_DB;
  - the key-code constants `KEY_STAR`=4'hA and `KEY_HASH`=4'hB;
  - the combinational function that maps column index and row index to a code.
- The debounce counter is small enough to stay inline. Everything else lives in the single module `keypad_scanner`.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE`=8.
- Reset: assert `rst` for 2 cycles. Then C rotates 001, 010, 100, 001 every 4 cycles, `Enable` stays 0 and `Num`=0.
- Clean press: R2 is high whenever C2 is driven, held for 40 cycles. Result: exactly one `Enable` with `Num`=5, and C2 stays frozen while the key is held.
- Bounce: R3 toggles with C1 every 3 cycles for 30 cycles, then stays stable. Result: no `Enable` during bouncing, then one `Enable` with `Num`=7.
- Release glitch: after key `#` is accepted, R4 drops for 5 cycles and returns, then releases for 20 cycles. Result: no second `Enable`, and scanning resumes at C1.
- Invalid: R1 and R2 high together. Result: no `Enable` and scanning continues. Pressing `*` alone then gives `Num`=4'hA.
- Reset mid-debounce: assert `rst` in PRESS_DB with key 9. Result: outputs return to reset values and no `Enable` is produced.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// keypad_pkg: shared definitions for the 4x3 keypad scanner.
//   kp_state_t       : scanner FSM states
//   KEY_STAR/KEY_HASH: codes reported for the '*' and '#' keys
//   key_code()       : maps (column index, row index) to the 4-bit key code
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } kp_state_t;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  // col: 0..2 for C1..C3, row: 0..3 for R1..R4.
  // Rows 1-3 are the digits row*3+col+1; the bottom row is '*', 0, '#'.
  function automatic logic [3:0] key_code(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] r4;
    logic [3:0] c4;
    r4 = {2'b00, row};
    c4 = {2'b00, col};
    if (row == 2'd3) begin
      case (col)
        2'd0:    key_code = KEY_STAR;
        2'd1:    key_code = 4'h0;
        default: key_code = KEY_HASH;
      endcase
    end else begin
      key_code = (r4 * 4'd3) + c4 + 4'd1;
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: pins between the scanner and the keypad matrix.
//   R1..R4 : row returns, active-high, asynchronous to the scanner clock
//   C1..C3 : column drives, active-high, exactly one high
//   Num    : code of the last accepted key
//   Enable : one-cycle strobe marking a newly accepted key
// master = scanner side, slave = keypad / consumer side.
// Handshake: Enable is a single-cycle valid with no ready; Num is valid in
// the cycle Enable is high and holds until the next accepted key.
interface keypad_scanner_if;
  logic       R1;
  logic       R2;
  logic       R3;
  logic       R4;
  logic       C1;
  logic       C2;
  logic       C3;
  logic [3:0] Num;
  logic       Enable;

  modport master (
    input  R1, R2, R3, R4,
    output C1, C2, C3, Num, Enable
  );

  modport slave (
    output R1, R2, R3, R4,
    input  C1, C2, C3, Num, Enable
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: active scanner for a 4x3 telephone keypad.
// Drives columns one-hot in rotation, synchronizes the row returns,
// debounces a single pressed key, locks onto it until full release and
// reports each accepted press as a key code with a one-cycle strobe.
// Ports:
//   clk       : clock, all logic on the rising edge
//   rst       : synchronous active-high reset
//   kp        : keypad_scanner_if.master (rows in, columns/Num/Enable out)
//   dbg_state : current FSM state (kp_state_t encoding)
// Parameters:
//   SCAN_DIV  : cycles each column is driven (>= 4)
//   DEBOUNCE  : stable cycles required to accept a press or a release (>= 2)
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 1024
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp,
  output logic [1:0]        dbg_state
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE - 1);

  localparam logic [1:0] ST_SCAN     = SCAN;
  localparam logic [1:0] ST_PRESS_DB = PRESS_DB;
  localparam logic [1:0] ST_HELD     = HELD;
  localparam logic [1:0] ST_REL_DB   = REL_DB;

  logic [3:0]    row_meta;
  logic [3:0]    rowv;
  logic [1:0]    state;
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] db_cnt;
  logic [1:0]    col_idx;
  logic [3:0]    lat_row;
  logic [3:0]    num_q;
  logic          en_q;

  logic          row_valid;
  logic [1:0]    row_idx;
  logic [1:0]    col_next;

  // Two-flop synchronizer for the asynchronous row returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'b0000;
      rowv     <= 4'b0000;
    end else begin
      row_meta <= {kp.R4, kp.R3, kp.R2, kp.R1};
      rowv     <= row_meta;
    end
  end

  always_comb begin
    // Exactly one row bit set; zero or several rows mean no key.
    row_valid = (rowv != 4'b0000) && ((rowv & (rowv - 4'd1)) == 4'b0000);
    col_next  = (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
    row_idx   = 2'd0;
    case (lat_row)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_SCAN;
      div_cnt <= '0;
      db_cnt  <= '0;
      col_idx <= 2'd0;
      lat_row <= 4'b0000;
      num_q   <= 4'h0;
      en_q    <= 1'b0;
    end else begin
      en_q <= 1'b0;
      case (state)
        ST_SCAN: begin
          // Sample only at slot end: by then the 2-cycle synchronizer
          // latency is covered and rowv reflects the current column.
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (row_valid) begin
              lat_row <= rowv;
              db_cnt  <= '0;
              state   <= ST_PRESS_DB;
            end else begin
              col_idx <= col_next;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_PRESS_DB: begin
          if (rowv != lat_row) begin
            state   <= ST_SCAN;
            col_idx <= col_next;
            div_cnt <= '0;
            db_cnt  <= '0;
          end else if (db_cnt == DB_LAST) begin
            state  <= ST_HELD;
            num_q  <= key_code(col_idx, row_idx);
            en_q   <= 1'b1;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          // Extra keys are ignored here; only an all-zero row vector
          // starts the release debounce.
          if (rowv == 4'b0000) begin
            db_cnt <= '0;
            state  <= ST_REL_DB;
          end
        end
        ST_REL_DB: begin
          if (rowv != 4'b0000) begin
            db_cnt <= '0;
            state  <= ST_HELD;
          end else if (db_cnt == DB_LAST) begin
            state   <= ST_SCAN;
            col_idx <= col_next;
            div_cnt <= '0;
            db_cnt  <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_SCAN;
          div_cnt <= '0;
          db_cnt  <= '0;
        end
      endcase
    end
  end

  // col_idx only ever holds 0..2, so the drive is always one-hot.
  assign kp.C1     = (col_idx == 2'd0);
  assign kp.C2     = (col_idx == 2'd1);
  assign kp.C3     = (col_idx == 2'd2);
  assign kp.Num    = num_q;
  assign kp.Enable = en_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_PRESS_DB = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic [11:0] pressed;  // bit row*3+col: key at that matrix position is down

  int n_cmp;
  int n_err;
  int onehot_viol;
  int en_double;
  logic en_prev;

  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  keypad_scanner_if kp_if ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .kp        (kp_if.master),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive keypad matrix: a row is high when a down key joins it to the
  // currently driven column.
  assign kp_if.R1 = (pressed[0]  & kp_if.C1) | (pressed[1]  & kp_if.C2) | (pressed[2]  & kp_if.C3);
  assign kp_if.R2 = (pressed[3]  & kp_if.C1) | (pressed[4]  & kp_if.C2) | (pressed[5]  & kp_if.C3);
  assign kp_if.R3 = (pressed[6]  & kp_if.C1) | (pressed[7]  & kp_if.C2) | (pressed[8]  & kp_if.C3);
  assign kp_if.R4 = (pressed[9]  & kp_if.C1) | (pressed[10] & kp_if.C2) | (pressed[11] & kp_if.C3);

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if ({kp_if.C3, kp_if.C2, kp_if.C1} != 3'b001 &&
        {kp_if.C3, kp_if.C2, kp_if.C1} != 3'b010 &&
        {kp_if.C3, kp_if.C2, kp_if.C1} != 3'b100)
      onehot_viol++;
    if (kp_if.Enable && en_prev) en_double++;
    en_prev = kp_if.Enable;
    if (!rst && kp_if.Enable) got_q.push_back(kp_if.Num);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_phase(input string tag);
    check({tag, "_enables"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_num"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] s, input int max_cyc, input string tag);
    int k;
    k = 0;
    while (dbg_state !== s && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check(tag, dbg_state, s);
  endtask

  task automatic press_for(input logic [11:0] mask, input int n);
    pressed = mask;
    cycles(n);
  endtask

  task automatic release_all(input int n);
    pressed = 12'b0;
    cycles(n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_err = 0; onehot_viol = 0; en_double = 0; en_prev = 1'b0;
    pressed = 12'b0;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;

    // Reset values, then rotation 001,010,100,001 every 4 cycles.
    check("rst_num", kp_if.Num, 4'h0);
    check("rst_enable", kp_if.Enable, 1'b0);
    check("rst_state", dbg_state, S_SCAN);
    for (int i = 0; i < 13; i++) begin
      check($sformatf("rotate_%0d", i), {kp_if.C3, kp_if.C2, kp_if.C1}, 3'b001 << ((i / 4) % 3));
      @(negedge clk);
    end
    check_phase("reset");

    // Clean press of 5 (row 2, column 2).
    exp_q.push_back(4'h5);
    press_for(12'b0000_0001_0000, 40);
    check("held_col", {kp_if.C3, kp_if.C2, kp_if.C1}, 3'b010);
    check("held_state", dbg_state, S_HELD);
    release_all(30);
    check_phase("clean");

    // Bounce on 7 (row 3, column 1): toggles every 3 cycles for 30 cycles.
    for (int i = 0; i < 10; i++) begin
      pressed = (i % 2 == 0) ? 12'b0000_0100_0000 : 12'b0;
      cycles(3);
    end
    check_phase("bounce_quiet");
    exp_q.push_back(4'h7);
    press_for(12'b0000_0100_0000, 40);
    release_all(30);
    check_phase("bounce");

    // '#' accepted, 5-cycle release glitch, then full release.
    exp_q.push_back(4'hB);
    press_for(12'b1000_0000_0000, 40);
    check("hash_col", {kp_if.C3, kp_if.C2, kp_if.C1}, 3'b100);
    release_all(5);
    press_for(12'b1000_0000_0000, 10);
    check("glitch_state", dbg_state, S_HELD);
    pressed = 12'b0;
    wait_state(S_SCAN, 30, "release_to_scan");
    check("resume_col", {kp_if.C3, kp_if.C2, kp_if.C1}, 3'b001);
    cycles(20);
    check_phase("glitch");

    // Invalid: keys 1 and 4 together (R1 and R2 both on C1).
    press_for(12'b0000_0000_1001, 40);
    check("invalid_state", dbg_state, S_SCAN);
    release_all(10);
    check_phase("invalid");
    exp_q.push_back(4'hA);
    press_for(12'b0010_0000_0000, 40);
    release_all(30);
    check_phase("star");

    // Reset while debouncing key 9 (row 3, column 3).
    pressed = 12'b0001_0000_0000;
    wait_state(S_PRESS_DB, 40, "reach_press_db");
    cycles(2);
    rst = 1'b1;
    cycles(1);
    check("mid_rst_col", {kp_if.C3, kp_if.C2, kp_if.C1}, 3'b001);
    check("mid_rst_num", kp_if.Num, 4'h0);
    check("mid_rst_enable", kp_if.Enable, 1'b0);
    check("mid_rst_state", dbg_state, S_SCAN);
    pressed = 12'b0;
    cycles(1);
    rst = 1'b0;
    cycles(30);
    check("post_rst_num", kp_if.Num, 4'h0);
    check_phase("mid_rst");

    check("col_onehot", onehot_viol, 0);
    check("enable_single", en_double, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
